// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the CPU pipeline stage registers.
package pipe_pkg;

  // ID/EX stage widths: control is WB+M+EX, payload is Rs/Rt/Rd/imm16/BusA/BusB/pc.
  localparam int CTRL_W_IDEX = 37;
  localparam int DATA_W_IDEX = 133;

  // Occupancy of a stage: nothing live, output live, or output live plus skid entry.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKIDF = 2'd2
  } pipe_state_e;

  // Control word of a NOP: every control bit deasserted.
  localparam logic [CTRL_W_IDEX-1:0] NOP_CTRL = {CTRL_W_IDEX{1'b0}};

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake carrying one control word and one payload word.
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 37,
  parameter int DATA_W = 133
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  // Producer side drives the transfer, consumer side answers with ready.
  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Event counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q;

  // Count up on each event until all ones, then hold.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      cnt_q <= {CNT_W{1'b0}};
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with hold, bubble, flush and optional skid entry.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_IDEX,
  parameter int DATA_W = DATA_W_IDEX,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stage_reg_if.slave  up,
  pipe_stage_reg_if.master dn,
  input  logic             stall,
  input  logic             bubble,
  input  logic             flush,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam bit SKID_EN = (SKID != 0);

  pipe_state_e       state_q, state_d;
  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_s;
  logic              accept_s;
  logic              bub_inc_s;
  logic              fl_inc_s;

  // Handshake decode and next-state selection in priority flush > stall > bubble > normal.
  always_comb begin
    in_ready_s  = !stall && !bubble && !flush && (state_q != SKIDF) &&
                  ((state_q == EMPTY) || dn.ready || (SKID_EN && (state_q == FULL)));
    accept_s    = up.valid && in_ready_s;
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    data_d      = data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    bub_inc_s   = 1'b0;
    fl_inc_s    = 1'b0;
    if (flush) begin
      // Payload is left in place; only control and occupancy are squashed.
      state_d  = EMPTY;
      ctrl_d   = {CTRL_W{1'b0}};
      fl_inc_s = 1'b1;
    end else if (stall) begin
      state_d = state_q;
    end else if (bubble) begin
      bub_inc_s = 1'b1;
      if (state_q == SKIDF) begin
        // A parked instruction survives the bubble and may still drain.
        if (dn.ready) begin
          ctrl_d  = skid_ctrl_q;
          data_d  = skid_data_q;
          state_d = FULL;
        end else begin
          state_d = SKIDF;
        end
      end else begin
        // NOP control, but the payload stays visible for hazard detection.
        ctrl_d  = {CTRL_W{1'b0}};
        data_d  = up.data;
        state_d = EMPTY;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept_s) begin
            ctrl_d  = up.ctrl;
            data_d  = up.data;
            state_d = FULL;
          end else begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (accept_s && dn.ready) begin
            ctrl_d  = up.ctrl;
            data_d  = up.data;
            state_d = FULL;
          end else if (accept_s) begin
            skid_ctrl_d = up.ctrl;
            skid_data_d = up.data;
            state_d     = SKIDF;
          end else if (dn.ready) begin
            state_d = EMPTY;
          end else begin
            state_d = FULL;
          end
        end
        SKIDF: begin
          if (dn.ready) begin
            ctrl_d  = skid_ctrl_q;
            data_d  = skid_data_q;
            state_d = FULL;
          end else begin
            state_d = SKIDF;
          end
        end
        default: begin
          state_d = EMPTY;
          ctrl_d  = {CTRL_W{1'b0}};
        end
      endcase
    end
    valid_d = (state_d != EMPTY);
  end

  // Output-side registers: occupancy, valid, control and payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      ctrl_q  <= {CTRL_W{1'b0}};
      data_q  <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  generate
    if (SKID_EN) begin : g_skid
      // One-entry buffer that parks an accepted instruction under backpressure.
      always_ff @(posedge clk) begin
        if (rst) begin
          skid_ctrl_q <= {CTRL_W{1'b0}};
          skid_data_q <= {DATA_W{1'b0}};
        end else begin
          skid_ctrl_q <= skid_ctrl_d;
          skid_data_q <= skid_data_d;
        end
      end
    end else begin : g_no_skid
      assign skid_ctrl_q = {CTRL_W{1'b0}};
      assign skid_data_q = {DATA_W{1'b0}};
    end
  endgenerate

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk(clk), .rst(rst), .clear_i(1'b0), .inc_i(bub_inc_s), .cnt_o(bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .clear_i(1'b0), .inc_i(fl_inc_s), .cnt_o(flush_cnt)
  );

  assign up.ready = in_ready_s;
  assign dn.valid = valid_q;
  assign dn.ctrl  = ctrl_q;
  assign dn.data  = data_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: one skid stage, one no-skid stage and one 2-bit-counter stage share stimulus.
module tb_pipe_stage_reg;
  localparam int CW = 37;
  localparam int DW = 133;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          stall, bubble, flush, out_ready;
  logic [15:0]   bcnt1, fcnt1, bcnt0, fcnt0;
  logic [1:0]    bcnts, fcnts;
  int            total = 0;
  int            bad = 0;

  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) up1 ();
  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) dn1 ();
  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) up0 ();
  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) dn0 ();
  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) ups ();
  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) dns ();

  assign up1.valid = in_valid; assign up1.ctrl = in_ctrl; assign up1.data = in_data;
  assign up0.valid = in_valid; assign up0.ctrl = in_ctrl; assign up0.data = in_data;
  assign ups.valid = in_valid; assign ups.ctrl = in_ctrl; assign ups.data = in_data;
  assign dn1.ready = out_ready; assign dn0.ready = out_ready; assign dns.ready = out_ready;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .up(up1), .dn(dn1), .stall(stall), .bubble(bubble),
    .flush(flush), .bubble_cnt(bcnt1), .flush_cnt(fcnt1));
  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .up(up0), .dn(dn0), .stall(stall), .bubble(bubble),
    .flush(flush), .bubble_cnt(bcnt0), .flush_cnt(fcnt0));
  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(2)) us (
    .clk(clk), .rst(rst), .up(ups), .dn(dns), .stall(stall), .bubble(bubble),
    .flush(flush), .bubble_cnt(bcnts), .flush_cnt(fcnts));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid = 1'b1; in_ctrl = c; in_data = d; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (dn1.valid !== 1'b0) begin bad++; $display("FAIL reset_valid act=%b exp=0", dn1.valid); end
    total++; if (dn1.ctrl !== 37'h0) begin bad++; $display("FAIL reset_ctrl act=%h exp=0", dn1.ctrl); end
    total++; if (dn1.data !== 133'h0) begin bad++; $display("FAIL reset_data act=%h exp=0", dn1.data); end
    total++; if (bcnt1 !== 16'd0 || fcnt1 !== 16'd0) begin bad++; $display("FAIL reset_cnt act=%0d/%0d exp=0/0", bcnt1, fcnt1); end
    total++; if (dn0.valid !== 1'b0) begin bad++; $display("FAIL reset_valid_noskid act=%b exp=0", dn0.valid); end
  endtask

  task automatic test_stream();
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      c = 37'h1_0000_0000 + 37'(i);
      d = 133'h1234_0000 + 133'(i * 3);
      in_valid = 1'b1; in_ctrl = c; in_data = d;
      #1;
      total++; if (up1.ready !== 1'b1) begin bad++; $display("FAIL stream_ready%0d act=%b exp=1", i, up1.ready); end
      step();
      total++; if (dn1.valid !== 1'b1 || dn1.ctrl !== c || dn1.data !== d) begin
        bad++; $display("FAIL stream_out%0d act=%b/%h/%h exp=1/%h/%h", i, dn1.valid, dn1.ctrl, dn1.data, c, d);
      end
    end
    in_valid = 1'b0;
    step();
    total++; if (dn1.valid !== 1'b0) begin bad++; $display("FAIL stream_drain act=%b exp=0", dn1.valid); end
    total++; if (bcnt1 !== 16'd0 || fcnt1 !== 16'd0) begin bad++; $display("FAIL stream_cnt act=%0d/%0d exp=0/0", bcnt1, fcnt1); end
  endtask

  task automatic test_load_use();
    logic [135:0] pat;
    pat = {17{8'h55}};
    load(37'hABC, 133'h11);
    total++; if (dn1.valid !== 1'b1 || dn1.ctrl !== 37'hABC) begin bad++; $display("FAIL lu_full act=%b/%h exp=1/abc", dn1.valid, dn1.ctrl); end
    bubble = 1'b1; in_valid = 1'b1; in_ctrl = 37'h777; in_data = pat[DW-1:0];
    #1;
    total++; if (up1.ready !== 1'b0) begin bad++; $display("FAIL lu_ready act=%b exp=0", up1.ready); end
    step();
    bubble = 1'b0; in_valid = 1'b0;
    total++; if (dn1.valid !== 1'b0 || dn1.ctrl !== 37'h0) begin bad++; $display("FAIL lu_nop act=%b/%h exp=0/0", dn1.valid, dn1.ctrl); end
    total++; if (dn1.data !== pat[DW-1:0]) begin bad++; $display("FAIL lu_data act=%h exp=%h", dn1.data, pat[DW-1:0]); end
    total++; if (bcnt1 !== 16'd1) begin bad++; $display("FAIL lu_cnt act=%0d exp=1", bcnt1); end
  endtask

  task automatic test_flush_vs_bubble();
    load(37'h77, 133'hD00D);
    flush = 1'b1; bubble = 1'b1; in_valid = 1'b1; in_ctrl = 37'h99; in_data = 133'hBEEF;
    #1;
    total++; if (up1.ready !== 1'b0) begin bad++; $display("FAIL fb_ready act=%b exp=0", up1.ready); end
    step();
    flush = 1'b0; bubble = 1'b0; in_valid = 1'b0;
    total++; if (dn1.valid !== 1'b0 || dn1.ctrl !== 37'h0) begin bad++; $display("FAIL fb_squash act=%b/%h exp=0/0", dn1.valid, dn1.ctrl); end
    total++; if (dn1.data !== 133'hD00D) begin bad++; $display("FAIL fb_data act=%h exp=d00d", dn1.data); end
    total++; if (fcnt1 !== 16'd1 || bcnt1 !== 16'd1) begin bad++; $display("FAIL fb_cnt act=%0d/%0d exp=1/1", fcnt1, bcnt1); end
  endtask

  task automatic test_stall();
    load(37'h5A, 133'h33);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_ctrl = 37'(i + 40); in_data = 133'(i + 90); out_ready = i[0];
      #1;
      total++; if (up1.ready !== 1'b0) begin bad++; $display("FAIL stall_ready%0d act=%b exp=0", i, up1.ready); end
      step();
      total++; if (dn1.valid !== 1'b1 || dn1.ctrl !== 37'h5A || dn1.data !== 133'h33) begin
        bad++; $display("FAIL stall_hold%0d act=%b/%h/%h exp=1/5a/33", i, dn1.valid, dn1.ctrl, dn1.data);
      end
      total++; if (bcnt1 !== 16'd1 || fcnt1 !== 16'd1) begin bad++; $display("FAIL stall_cnt%0d act=%0d/%0d exp=1/1", i, bcnt1, fcnt1); end
    end
    stall = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    total++; if (dn1.valid !== 1'b0) begin bad++; $display("FAIL stall_drain act=%b exp=0", dn1.valid); end
  endtask

  task automatic test_skid();
    load(37'hA, 133'hAAAA);
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 37'hB; in_data = 133'hBBBB;
    #1;
    total++; if (up1.ready !== 1'b1) begin bad++; $display("FAIL skid_ready_full act=%b exp=1", up1.ready); end
    total++; if (up0.ready !== 1'b0) begin bad++; $display("FAIL noskid_ready act=%b exp=0", up0.ready); end
    step();
    in_ctrl = 37'hC; in_data = 133'hCCCC;
    #1;
    total++; if (up1.ready !== 1'b0) begin bad++; $display("FAIL skid_ready_skidf act=%b exp=0", up1.ready); end
    total++; if (dn1.ctrl !== 37'hA || dn1.valid !== 1'b1) begin bad++; $display("FAIL skid_holdA act=%b/%h exp=1/a", dn1.valid, dn1.ctrl); end
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    total++; if (up1.ready !== 1'b0) begin bad++; $display("FAIL skid_ready_drain act=%b exp=0", up1.ready); end
    step();
    total++; if (dn1.valid !== 1'b1 || dn1.ctrl !== 37'hB || dn1.data !== 133'hBBBB) begin
      bad++; $display("FAIL skid_outB act=%b/%h/%h exp=1/b/bbbb", dn1.valid, dn1.ctrl, dn1.data);
    end
    total++; if (dn0.valid !== 1'b0 || dn0.ctrl !== 37'hA) begin bad++; $display("FAIL noskid_noB act=%b/%h exp=0/a", dn0.valid, dn0.ctrl); end
    step();
    total++; if (dn1.valid !== 1'b0) begin bad++; $display("FAIL skid_empty act=%b exp=0", dn1.valid); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp2;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (bcnts !== 2'd0 || fcnts !== 2'd0) begin bad++; $display("FAIL sat_reset0 act=%0d/%0d exp=0/0", bcnts, fcnts); end
    bubble = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      exp2 = (i > 3) ? 2'd3 : 2'(i);
      total++; if (bcnts !== exp2) begin bad++; $display("FAIL sat_cnt%0d act=%0d exp=%0d", i, bcnts, exp2); end
      total++; if (bcnt1 !== 16'(i)) begin bad++; $display("FAIL wide_cnt%0d act=%0d exp=%0d", i, bcnt1, i); end
    end
    bubble = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (bcnts !== 2'd0 || bcnt1 !== 16'd0) begin bad++; $display("FAIL sat_reset act=%0d/%0d exp=0/0", bcnts, bcnt1); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
    stall = 1'b0; bubble = 1'b0; flush = 1'b0; out_ready = 1'b1;
    test_reset();
    test_stream();
    test_load_use();
    test_flush_vs_bubble();
    test_stall();
    test_skid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the 5-stage CPU, replacing the hand-sized per-stage registers (ID/EX first, then EX/MEM and MEM/WB). It carries a control field and a data field under a valid/ready handshake. It supports hold (stall), bubble insertion (load-use), flush (branch/jump squash), and an optional one-entry skid buffer for downstream backpressure. Saturating event counters expose bubble and flush activity to the debug port.

## Interface
- CTRL_W, 37, control bits (WB+M+EX); cleared on bubble/flush/reset
- DATA_W, 133, payload bits (Rs, Rt, Rd, imm16, BusA, BusB, pc); never cleared except by reset
- SKID, 1, 0 = no skid entry, 1 = one-entry skid buffer
- CNT_W, 16, width of event counters
- clk  in  1  stage clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage accepts in_ctrl/in_data this cycle
- in_ctrl  in  CTRL_W  upstream control
- in_data  in  DATA_W  upstream payload
- stall  in  1  hold entire stage, accept nothing
- bubble  in  1  load-use: emit NOP control, keep payload, refuse input
- flush  in  1  squash stage contents (control and valid)
- out_valid  out  1  output holds a live instruction
- out_ready  in  1  downstream consumes output
- out_ctrl  out  CTRL_W  registered control
- out_data  out  DATA_W  registered payload
- bubble_cnt  out  CNT_W  saturating count of inserted bubbles
- flush_cnt  out  CNT_W  saturating count of flush cycles

## Operation
- States: EMPTY (out_valid=0), FULL (output live), SKIDF (output live and skid entry occupied; reachable only when SKID=1).
- Per-edge priority: rst > flush > stall > bubble > normal.
- rst: state EMPTY; out_valid=0, out_ctrl=0, out_data=0; skid cleared; counters=0.
- flush: state EMPTY, out_valid=0, out_ctrl=0, skid entry discarded; out_data unchanged. flush_cnt+1 (saturating).
- stall: all registers hold; in_ready=0; counters unchanged.
- bubble: out_ctrl<=0, out_valid<=0, out_data<=in_data (payload still visible to hazard detection); in_ready=0; bubble_cnt+1 (saturating). If the state is SKIDF, the skid entry is kept and bubble only blocks input.
- Normal accept: transfer when in_valid & in_ready → out_ctrl/out_data <= input, out_valid<=1.
- in_ready = !stall & !bubble & !flush & (state==EMPTY | out_ready | (SKID & state==FULL)).
- Backpressure: FULL & !out_ready & accept (SKID=1) → input goes to skid, state SKIDF. SKIDF & out_ready → output loads skid entry, state FULL; in_ready=0 while in SKIDF.
- FULL & out_ready & no accept → EMPTY. EMPTY & no accept → stays EMPTY.
- Counters stop at 2^CNT_W−1 and do not wrap.

## Timing
- Latency 1 cycle, in_valid&in_ready to out_valid.
- Throughput 1 per cycle when out_ready stays high.
- in_ready is combinational from stall, bubble, flush, out_ready and state. There is no path from in_valid to in_ready.
- Outputs are all registered. The skid path adds no extra latency on drain.
- Simultaneous flush+bubble: flush wins and bubble_cnt does not increment.
- Simultaneous stall+bubble: stall wins, no bubble, no count.
- rst asserted mid-transfer: the transfer is dropped and the reset values apply on the same edge.

## Structure
- Shared package pipe_pkg: localparams CTRL_W_IDEX=37 and DATA_W_IDEX=133, a state enum {EMPTY, FULL, SKIDF}, and the NOP control constant (all zeros).
- Sub-module sat_counter (CNT_W, inc, clear) is instantiated twice for bubble_cnt and flush_cnt.
- The skid entry is generated only when SKID=1. When SKID=0 the SKIDF state is unreachable and is optimised away.

## Test plan
- Reset then stream: rst 1 cycle, then 4 back-to-back inputs ctrl=0x1_0000_0001..4 with out_ready=1 → out_valid rises 1 cycle after each accept, data in order, bubble_cnt=flush_cnt=0.
- Load-use: FULL with ctrl=0xABC, then bubble=1 for 1 cycle with in_data=0x55… → out_ctrl=0, out_valid=0, out_data=0x55…, in_ready=0, bubble_cnt=1.
- Flush vs bubble: flush=1 and bubble=1 on the same cycle → state EMPTY, out_data unchanged, flush_cnt=1, bubble_cnt=0.
- Stall hold: stall=1 for 3 cycles with changing inputs → outputs constant, in_ready=0 throughout, counters unchanged.
- Skid (SKID=1): FULL with A, out_ready=0, accept B → state SKIDF, in_ready=0. Raise out_ready → A consumed, output=B next cycle, then EMPTY. With SKID=0 the same stimulus gives in_ready=0 and B is not accepted.
- Saturation: CNT_W=2, 5 bubbles → bubble_cnt=3. Then rst → 0.
